// File: rtl/sra_seq.sv
// sra_seq: multi-cycle shifter (sll/srl/sra) moving one bit position per clock
module sra_seq #(
    parameter int L1 = 8,
    parameter int L2 = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    op,
    input  logic [L1-1:0] in1,
    input  logic [L2-1:0] in2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [L1-1:0] out,
    output logic          busy
);
    localparam int CW = $clog2(L1 + 1);
    localparam int AW = (L2 > CW) ? L2 : CW;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [L1-1:0] data_q, data_d;
    logic [L1-1:0] out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] amt;
    logic [CW-1:0] n;
    logic [L1-1:0] shifted;

    // clamp the amount to L1 so oversized requests saturate instead of wrapping
    always_comb begin
        amt = AW'(in2);
        n   = (amt >= AW'(L1)) ? CW'(L1) : CW'(amt);
    end

    // one-position shift of the working register; reserved opcode behaves as srl
    always_comb begin
        shifted = (op_q == 2'b00) ? {data_q[L1-2:0], 1'b0}
                                  : {(op_q == 2'b10) & data_q[L1-1], data_q[L1-1:1]};
    end

    // next-state logic; the result register is loaded only on entry to DONE
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        out_d   = out_q;
        case (state_q)
            IDLE: if (in_valid) begin
                data_d  = in1;
                op_d    = op;
                cnt_d   = n;
                state_d = (n == '0) ? DONE : SHIFT;
                out_d   = (n == '0) ? in1 : out_q;
            end
            SHIFT: begin
                data_d  = shifted;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? DONE : SHIFT;
                out_d   = (cnt_q == CW'(1)) ? shifted : out_q;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // state registers with synchronous reset taking priority over any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign out       = out_q;
endmodule

// File: tb/tb_sra_seq.sv
// tb_sra_seq: directed checks of the sequential shifter handshake, latency and results
module tb_sra_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] op = 2'b00;
    logic [7:0] in1 = 8'h00;
    logic [7:0] in2 = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out;
    logic       busy;
    int         total = 0;
    int         bad = 0;

    sra_seq #(.L1(8), .L2(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s_%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] e, input int ecyc, input bit hs);
        int cyc;
        in_valid = 1'b1;
        op = o;
        in1 = a;
        in2 = b;
        chk(tag, "rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        op = 2'b00;
        in1 = 8'h3C;
        in2 = 8'd1;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            chk(tag, "busy_sh", {busy, in_ready}, 2'b10);
            tick();
            cyc++;
        end
        chk(tag, "lat", cyc, ecyc);
        chk(tag, "out", out, e);
        chk(tag, "busy", {busy, in_ready}, 2'b10);
        if (hs) begin
            out_ready = 1'b1;
            tick();
            chk(tag, "idle", {in_ready, out_valid, busy}, 3'b100);
            chk(tag, "held", out, e);
        end
    endtask

    initial begin
        bit seen;
        tick();
        tick();
        rst = 1'b0;
        chk("reset", "flags", {in_ready, out_valid, busy}, 3'b100);
        chk("reset", "out", out, 8'h00);

        run("sra3", 2'b10, 8'h90, 8'd3, 8'hF2, 3, 1'b1);
        run("srl3", 2'b01, 8'h90, 8'd3, 8'h12, 3, 1'b1);
        run("sll1", 2'b00, 8'h81, 8'd1, 8'h02, 1, 1'b1);
        run("rsv3", 2'b11, 8'h90, 8'd3, 8'h12, 3, 1'b1);
        run("sra0", 2'b10, 8'hA5, 8'd0, 8'hA5, 0, 1'b1);
        run("sra_sat", 2'b10, 8'h80, 8'd200, 8'hFF, 8, 1'b1);
        run("srl_sat", 2'b01, 8'h80, 8'd200, 8'h00, 8, 1'b1);
        run("sll_sat", 2'b00, 8'hFF, 8'd8, 8'h00, 8, 1'b1);

        out_ready = 1'b0;
        run("bp", 2'b10, 8'h90, 8'd3, 8'hF2, 3, 1'b0);
        in_valid = 1'b1;
        op = 2'b00;
        in1 = 8'h55;
        in2 = 8'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp", "stall", {in_ready, out_valid, busy}, 3'b011);
            chk("bp", "out", out, 8'hF2);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp", "release", {in_ready, out_valid, busy}, 3'b100);
        chk("bp", "held", out, 8'hF2);
        run("sll7", 2'b00, 8'h01, 8'd7, 8'h80, 7, 1'b1);

        in_valid = 1'b1;
        op = 2'b10;
        in1 = 8'h80;
        in2 = 8'd6;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("rst_mid", "shifting", {in_ready, out_valid, busy}, 3'b001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid", "flags", {in_ready, out_valid, busy}, 3'b100);
        chk("rst_mid", "out", out, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen |= out_valid;
        end
        chk("rst_mid", "no_result", seen, 1'b0);
        run("srl4", 2'b01, 8'hF0, 8'd4, 8'h0F, 4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
